// File: rtl/bg_pkg.sv
// Shared definitions for the background-subtraction core: RGB565 field layout,
// FSM state encoding and the per-channel absolute difference.
package bg_pkg;

  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;
  localparam int CH_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } bg_state_e;

  // R and B are zero-extended by the caller so all channels share one width.
  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    logic signed [CH_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = (d < 0) ? CH_W'(-d) : CH_W'(d);
  endfunction

endpackage

// File: rtl/bg_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port
// (read latency 1). Contents are not reset.
module bg_acc_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/bg_subtract_core.sv
// Running-average background model and foreground detector for an RGB565 stream.
// Optional foreground pixel counter enabled by defining FG_COUNT_EN.
module bg_subtract_core
  import bg_pkg::*;
#(
  parameter int FRAME_W     = 160,
  parameter int FRAME_H     = 140,
  parameter int ALPHA_SHIFT = 6,
  parameter int TH_W        = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sof,
  input  logic            pix_valid,
  input  logic [15:0]     pix_in,
  input  logic            learn_en,
  input  logic            init_req,
  input  logic [TH_W-1:0] threshold,
  output logic            out_valid,
  output logic [15:0]     pix_out,
  output logic [15:0]     bg_out,
  output logic            fg_mask,
  output logic            frame_done,
  output logic            err_overflow,
  output logic            err_short
`ifdef FG_COUNT_EN
  ,
  output logic [$clog2(FRAME_W*FRAME_H+1)-1:0] fg_count
`endif
);

  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int AW     = $clog2(FRAME_PIXELS);
  localparam int RW     = R_W + ALPHA_SHIFT;
  localparam int GW     = G_W + ALPHA_SHIFT;
  localparam int ACC_W  = 16 + 3 * ALPHA_SHIFT;
  localparam int CMP_W  = (TH_W > CH_W) ? TH_W : CH_W;

  // acc - acc/2^ALPHA_SHIFT + pix; bounded by max_pix << ALPHA_SHIFT, never wraps.
  function automatic logic [GW-1:0] leak_add(input logic [GW-1:0]   acc,
                                             input logic [CH_W-1:0] pix);
    leak_add = acc - (acc >> ALPHA_SHIFT) + GW'(pix);
  endfunction

  bg_state_e       r_state, w_state_cur, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_cur, w_addr_nxt;
  logic            r_full, w_full_cur, w_full_nxt;
  logic            r_init_pend, w_init_pend, w_enter_init;
  logic            w_accept, w_drop, w_last, w_short;

  always_comb begin
    w_init_pend  = r_init_pend | init_req;
    w_enter_init = sof && ((r_state != ST_RUN) || w_init_pend);
    w_state_cur  = r_state;
    w_addr_cur   = r_addr;
    w_full_cur   = r_full;
    if (sof) begin
      w_state_cur = w_enter_init ? ST_INIT : ST_RUN;
      w_addr_cur  = '0;
      w_full_cur  = 1'b0;
    end
    w_short     = sof && (r_state != ST_IDLE) && !r_full;
    w_accept    = pix_valid && (w_state_cur != ST_IDLE) && !w_full_cur;
    w_drop      = pix_valid && (w_state_cur != ST_IDLE) && w_full_cur;
    w_last      = (w_addr_cur == AW'(FRAME_PIXELS - 1));
    w_addr_nxt  = w_addr_cur;
    w_full_nxt  = w_full_cur;
    w_state_nxt = w_state_cur;
    if (w_accept) begin
      w_addr_nxt = w_last ? '0 : w_addr_cur + AW'(1);
      w_full_nxt = w_last;
      if (w_last && (w_state_cur == ST_INIT)) w_state_nxt = ST_RUN;
    end
  end

  logic r_vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_full       <= 1'b0;
      r_init_pend  <= 1'b0;
      r_vld_p0     <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_full       <= w_full_nxt;
      r_init_pend  <= w_enter_init ? 1'b0 : w_init_pend;
      r_vld_p0     <= w_accept;
      err_overflow <= err_overflow | w_drop;
      err_short    <= err_short | w_short;
    end
  end

  // Stage 0: capture the pixel and its context while the RAM read is in flight
  logic [15:0]   r_pix_p0;
  logic [AW-1:0] r_addr_p0;
  logic          r_init_p0, r_learn_p0, r_last_p0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pix_p0   <= pix_in;
      r_addr_p0  <= w_addr_cur;
      r_init_p0  <= (w_state_cur == ST_INIT);
      r_learn_p0 <= learn_en;
      r_last_p0  <= w_last;
    end
  end

  logic [ACC_W-1:0] w_rdata, w_wdata;
  logic             w_we;

  bg_acc_ram #(
    .DEPTH (FRAME_PIXELS),
    .WIDTH (ACC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr_p0),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (w_addr_cur),
    .o_rdata (w_rdata)
  );

  // Stage 1: RAM data valid; update the model and classify the pixel
  logic [RW-1:0]   w_acc_r, w_acc_b, w_acc_r_nxt, w_acc_b_nxt;
  logic [GW-1:0]   w_acc_g, w_acc_g_nxt;
  logic [R_W-1:0]  w_pix_r, w_bg_r;
  logic [G_W-1:0]  w_pix_g, w_bg_g;
  logic [B_W-1:0]  w_pix_b, w_bg_b;
  logic [CH_W-1:0] w_d_r, w_d_g, w_d_b;
  logic [15:0]     w_bg;
  logic            w_fg;

  always_comb begin
    w_pix_r = r_pix_p0[R_LSB +: R_W];
    w_pix_g = r_pix_p0[G_LSB +: G_W];
    w_pix_b = r_pix_p0[B_LSB +: B_W];
    w_acc_r = w_rdata[ACC_W-1 -: RW];
    w_acc_g = w_rdata[GW+RW-1 -: GW];
    w_acc_b = w_rdata[RW-1:0];
    w_bg_r  = w_acc_r[RW-1 -: R_W];
    w_bg_g  = w_acc_g[GW-1 -: G_W];
    w_bg_b  = w_acc_b[RW-1 -: B_W];
    w_d_r   = abs_diff(CH_W'(w_pix_r), CH_W'(w_bg_r));
    w_d_g   = abs_diff(w_pix_g, w_bg_g);
    w_d_b   = abs_diff(CH_W'(w_pix_b), CH_W'(w_bg_b));
    if (r_init_p0) begin
      w_acc_r_nxt = RW'(w_pix_r) << ALPHA_SHIFT;
      w_acc_g_nxt = GW'(w_pix_g) << ALPHA_SHIFT;
      w_acc_b_nxt = RW'(w_pix_b) << ALPHA_SHIFT;
      w_bg        = r_pix_p0;
      w_fg        = 1'b0;
    end else begin
      w_acc_r_nxt = RW'(leak_add(GW'(w_acc_r), CH_W'(w_pix_r)));
      w_acc_g_nxt = leak_add(w_acc_g, w_pix_g);
      w_acc_b_nxt = RW'(leak_add(GW'(w_acc_b), CH_W'(w_pix_b)));
      w_bg        = {w_bg_r, w_bg_g, w_bg_b};
      w_fg        = (CMP_W'(w_d_r) > CMP_W'(threshold)) ||
                    (CMP_W'(w_d_g) > CMP_W'(threshold)) ||
                    (CMP_W'(w_d_b) > CMP_W'(threshold));
    end
    w_wdata = {w_acc_r_nxt, w_acc_g_nxt, w_acc_b_nxt};
    w_we    = r_vld_p0 && (r_init_p0 || r_learn_p0);
  end

  // Stage 2: registered outputs; frame_done trails the last output by one cycle
  logic r_last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      pix_out    <= '0;
      bg_out     <= '0;
      fg_mask    <= 1'b0;
      r_last_p1  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_vld_p0;
      r_last_p1  <= r_vld_p0 && r_last_p0;
      frame_done <= r_last_p1;
      if (r_vld_p0) begin
        pix_out <= r_pix_p0;
        bg_out  <= w_bg;
        fg_mask <= w_fg;
      end
    end
  end

`ifdef FG_COUNT_EN
  localparam int FC_W = $clog2(FRAME_PIXELS + 1);
  logic [FC_W-1:0] r_fg_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fg_cnt <= '0;
      fg_count <= '0;
    end else if (frame_done) begin
      fg_count <= r_fg_cnt;
      r_fg_cnt <= FC_W'(out_valid && fg_mask);
    end else if (out_valid && fg_mask) begin
      r_fg_cnt <= r_fg_cnt + FC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bg_subtract_core.sv
// Directed bench for bg_subtract_core on a 16x8 frame: vector table for the
// classifier plus frame-level sequences for INIT, learning, errors and reset.
module tb_bg_subtract_core;

  localparam int FW   = 16;
  localparam int FH   = 8;
  localparam int NPIX = FW * FH;
  localparam int THW  = 6;
  localparam int NV   = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sof = 1'b0;
  logic            pix_valid = 1'b0;
  logic [15:0]     pix_in = '0;
  logic            learn_en = 1'b0;
  logic            init_req = 1'b0;
  logic [THW-1:0]  threshold = '0;
  logic            out_valid;
  logic [15:0]     pix_out, bg_out;
  logic            fg_mask, frame_done, err_overflow, err_short;
`ifdef FG_COUNT_EN
  logic [$clog2(NPIX+1)-1:0] fg_count;
`endif

  bg_subtract_core #(
    .FRAME_W     (FW),
    .FRAME_H     (FH),
    .ALPHA_SHIFT (6),
    .TH_W        (THW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof          (sof),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .learn_en     (learn_en),
    .init_req     (init_req),
    .threshold    (threshold),
    .out_valid    (out_valid),
    .pix_out      (pix_out),
    .bg_out       (bg_out),
    .fg_mask      (fg_mask),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
`ifdef FG_COUNT_EN
    .fg_count     (fg_count),
`endif
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: tallies outputs and checks bg_out against the phase expectation
  int          n_valid = 0, n_fg = 0, n_done = 0, n_bg_bad = 0, fg_cyc = 0;
  logic        mon_chk_bg = 1'b0;
  logic [15:0] mon_bg = '0;

  always @(negedge clk) begin
    if (out_valid) begin
      n_valid++;
      if (fg_mask) begin
        n_fg++;
        fg_cyc = cyc;
      end
      if (mon_chk_bg && (bg_out !== mon_bg)) n_bg_bad++;
    end
    if (frame_done) n_done++;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int b_valid, b_fg, b_done, b_bad, drv_cyc;

  task automatic snap();
    b_valid = n_valid;
    b_fg    = n_fg;
    b_done  = n_done;
    b_bad   = n_bg_bad;
  endtask

  task automatic check_frame(input string name, input int exp_valid, input int exp_fg,
                             input int exp_done);
    check({name, " valid count"}, n_valid - b_valid, exp_valid);
    check({name, " fg count"}, n_fg - b_fg, exp_fg);
    check({name, " frame_done count"}, n_done - b_done, exp_done);
    check({name, " bg mismatches"}, n_bg_bad - b_bad, 0);
  endtask

  // Pixels [alt_lo, alt_lo+alt_n) carry alt_p, the rest carry p; then drain.
  task automatic send_frame(input int n, input bit with_sof, input logic [15:0] p,
                            input int alt_lo, input int alt_n, input logic [15:0] alt_p);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof       = with_sof && (i == 0);
      pix_valid = 1'b1;
      pix_in    = ((i >= alt_lo) && (i < alt_lo + alt_n)) ? alt_p : p;
      if (i == alt_lo) drv_cyc = cyc;
    end
    @(negedge clk);
    sof       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0]    pix;
    logic [THW-1:0] th;
    logic           exp_fg;
  } vec_t;

  vec_t vt [NV];

  initial begin
    // Model is R=16 G=32 B=16 (0x8410) when the table runs
    vt[0]  = '{16'h8410, 6'd0,  1'b0};
    vt[1]  = '{16'hFFFF, 6'd15, 1'b1};
    vt[2]  = '{16'hFFFF, 6'd31, 1'b0};
    vt[3]  = '{16'hFFFF, 6'd30, 1'b1};
    vt[4]  = '{16'h0000, 6'd15, 1'b1};
    vt[5]  = '{16'h0000, 6'd32, 1'b0};
    vt[6]  = '{16'hFC10, 6'd14, 1'b1};
    vt[7]  = '{16'hFC10, 6'd15, 1'b0};
    vt[8]  = '{16'h8400, 6'd15, 1'b1};
    vt[9]  = '{16'h8430, 6'd0,  1'b1};
    vt[10] = '{16'h8430, 6'd1,  1'b0};
    vt[11] = '{16'h0000, 6'd63, 1'b0};

    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset pix_out", pix_out, 0);
    check("reset bg_out", bg_out, 0);
    check("reset fg_mask", fg_mask, 0);
    check("reset frame_done", frame_done, 0);
    check("reset err_overflow", err_overflow, 0);
    check("reset err_short", err_short, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // INIT frame seeds the model with 0x8410
    learn_en = 1'b1; threshold = '0; mon_chk_bg = 1'b1; mon_bg = 16'h8410;
    snap();
    send_frame(NPIX, 1'b1, 16'h8410, 0, 0, 16'h0);
    check_frame("init frame", NPIX, 0, 1);
    check("init err_short", err_short, 0);

    // RUN: a single bright pixel is the only foreground, two cycles after input
    learn_en = 1'b0; threshold = 6'd15;
    snap();
    send_frame(NPIX, 1'b1, 16'h8410, 5, 1, 16'hFFFF);
    check_frame("single fg frame", NPIX, 1, 1);
    check("fg latency cycles", fg_cyc - drv_cyc, 2);

    // Classifier vectors, one pixel at a time, then pad the frame out
    snap();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      sof = (i == 0); pix_valid = 1'b1; pix_in = vt[i].pix; threshold = vt[i].th;
      @(negedge clk);
      sof = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d fg_mask", i), fg_mask, vt[i].exp_fg);
      check($sformatf("vec%0d bg_out", i), bg_out, 16'h8410);
      check($sformatf("vec%0d pix_out", i), pix_out, vt[i].pix);
    end
    send_frame(NPIX - NV, 1'b0, 16'h8410, 0, 0, 16'h0);
    check("vector frame frame_done", n_done - b_done, 1);

    // Frozen model: three dark frames leave the background untouched
    threshold = 6'd15;
    snap();
    for (int f = 0; f < 3; f++) send_frame(NPIX, 1'b1, 16'h0000, 0, 0, 16'h0);
    check_frame("frozen frames", 3 * NPIX, 3 * NPIX, 3);

    // One learned dark frame decays the model to R=15 G=31 B=15
    learn_en = 1'b1;
    snap();
    send_frame(NPIX, 1'b1, 16'h0000, 0, 0, 16'h0);
    check_frame("learn frame", NPIX, NPIX, 1);
    learn_en = 1'b0; mon_bg = 16'h7BEF;
    snap();
    send_frame(NPIX, 1'b1, 16'h0000, 0, 0, 16'h0);
    check_frame("after learn frame", NPIX, NPIX, 1);

    // init_req re-seeds on the following sof
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
    threshold = '0; mon_bg = 16'h1234;
    snap();
    send_frame(NPIX, 1'b1, 16'h1234, 0, 0, 16'h0);
    check_frame("reseed frame", NPIX, 0, 1);
    snap();
    send_frame(NPIX, 1'b1, 16'h1234, 0, 0, 16'h0);
    check_frame("reseeded run frame", NPIX, 0, 1);
    check("err_short before short frame", err_short, 0);
    check("err_overflow before overflow", err_overflow, 0);

    // Reset in the middle of a frame
    mon_chk_bg = 1'b0;
    @(negedge clk); sof = 1'b1; pix_valid = 1'b1; pix_in = 16'h1234;
    repeat (50) begin
      @(negedge clk); sof = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk); pix_valid = 1'b0;
    check("midreset out_valid", out_valid, 0);
    check("midreset bg_out", bg_out, 0);
    check("midreset pix_out", pix_out, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_frame(5, 1'b0, 16'h4321, 0, 0, 16'h0);
    check("idle ignores pixels", n_valid - b_valid, 0);

    // Short INIT frame, then a full one
    snap();
    send_frame(100, 1'b1, 16'h5555, 0, 0, 16'h0);
    check("short frame no err yet", err_short, 0);
    send_frame(NPIX, 1'b1, 16'h2222, 0, 0, 16'h0);
    check("err_short set", err_short, 1);
    check_frame("short+init frames", 100 + NPIX, 0, 1);
    mon_chk_bg = 1'b1; mon_bg = 16'h2222;
    snap();
    send_frame(NPIX, 1'b1, 16'h2222, 0, 0, 16'h0);
    check_frame("post-short run frame", NPIX, 0, 1);

    // Overflow: extra pixels without sof are dropped
    snap();
    check("err_overflow clear", err_overflow, 0);
    send_frame(NPIX + 5, 1'b1, 16'h2222, 0, 0, 16'h0);
    check_frame("overflow frame", NPIX, 0, 1);
    check("err_overflow set", err_overflow, 1);
    check("err_short sticky", err_short, 1);

    // 37 foreground pixels in one frame
    threshold = 6'd15;
    snap();
    send_frame(NPIX, 1'b1, 16'h2222, 10, 37, 16'hFFFF);
    check_frame("fg37 frame", NPIX, 37, 1);
`ifdef FG_COUNT_EN
    check("fg_count", fg_count, 37);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
